// File: rtl/mix_columns_seq_if.sv
// AES state type and the accept/emit handshake bundle for mix_columns_seq.
// state[c][r] packs column 0 / row 0 into the most significant byte.
package mix_columns_seq_pkg;
   typedef logic [0:3][0:3][7:0] t_opaque_AESState;
endpackage

interface mix_columns_seq_if;
   import mix_columns_seq_pkg::*;

   logic             in_valid;
   logic             in_ready;
   t_opaque_AESState in_state;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   t_opaque_AESState out_state;

   modport master (
      output in_valid, in_state, in_last, out_ready,
      input  in_ready, out_valid, out_state
   );

   modport slave (
      input  in_valid, in_state, in_last, out_ready,
      output in_ready, out_valid, out_state
   );
endinterface

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: one shared column datapath processes a column per cycle;
// the final round bypasses the transform and emits the input state directly.
module mix_columns_seq
   import mix_columns_seq_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   mix_columns_seq_if.slave bus
);

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_busy = 2'd1;
   localparam logic [1:0] st_done = 2'd2;

   logic [1:0]       fsm;
   logic [1:0]       col_cnt;
   t_opaque_AESState work;
   t_opaque_AESState result;
   logic [0:3][7:0]  col_in;
   logic [0:3][7:0]  col_out;
   logic             accept;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul3(input logic [7:0] x);
      return xtime(x) ^ x;
   endfunction

   // NOTE: every combinational output is assigned on every path, so no latch can be inferred.
   always_comb begin
      col_in     = work[col_cnt];
      col_out[0] = xtime(col_in[0]) ^ mul3(col_in[1]) ^ col_in[2]        ^ col_in[3];
      col_out[1] = col_in[0]        ^ xtime(col_in[1]) ^ mul3(col_in[2]) ^ col_in[3];
      col_out[2] = col_in[0]        ^ col_in[1]        ^ xtime(col_in[2]) ^ mul3(col_in[3]);
      col_out[3] = mul3(col_in[0])  ^ col_in[1]        ^ col_in[2]        ^ xtime(col_in[3]);
   end

   assign bus.in_ready  = (fsm == st_idle);
   assign bus.out_valid = (fsm == st_done);
   assign bus.out_state = result;
   assign accept        = bus.in_valid & bus.in_ready;

   // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the data registers are cleared too, so an aborted block leaves no residue on out_state.
         fsm     <= st_idle;
         col_cnt <= 2'd0;
         work    <= '0;
         result  <= '0;
      end else begin
         case (fsm)
            st_idle: begin
               if (accept) begin
                  work    <= bus.in_state;
                  col_cnt <= 2'd0;
                  if (bus.in_last) begin
                     result <= bus.in_state;
                     fsm    <= st_done;
                  end else begin
                     fsm    <= st_busy;
                  end
               end
            end
            st_busy: begin
               result[col_cnt] <= col_out;
               col_cnt         <= col_cnt + 2'd1;
               if (col_cnt == 2'd3) fsm <= st_done;
            end
            st_done: begin
               if (bus.out_ready) fsm <= st_idle;
            end
            default: fsm <= st_idle;
         endcase
      end
   end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Scoreboard bench for mix_columns_seq: the driver queues expected states on accept,
// an independent monitor compares on every output cycle against the queue and a cycle model.
module tb_mix_columns_seq;
   import mix_columns_seq_pkg::*;

   typedef struct {
      t_opaque_AESState state;
      int               acc_cyc;
      int               lat;
   } exp_t;

   // FIPS-197 columns, edge-byte columns and the bypass pattern, packed column 0 first.
   localparam t_opaque_AESState st_a  = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam t_opaque_AESState exp_a = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam t_opaque_AESState st_e  = 128'hd4d4d4d5_c6c6c6c6_01010101_01010101;
   localparam t_opaque_AESState exp_e = 128'hd5d5d7d6_c6c6c6c6_01010101_01010101;
   localparam t_opaque_AESState st_b  = 128'h2d26314c_01010101_f20a225c_db135345;
   localparam t_opaque_AESState exp_b = 128'h4d7ebdf8_01010101_9fdc589d_8e4da1bc;
   localparam t_opaque_AESState st_p  = 128'h00112233_44556677_8899aabb_ccddeeff;
   localparam t_opaque_AESState junk  = 128'hdeadbeef_cafef00d_12345678_9abcdef0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mix_columns_seq_if bus ();

   mix_columns_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   n_total = 0;
   int   n_bad   = 0;
   int   cyc     = 0;
   exp_t q[$];
   logic chk_en  = 1'b0;
   logic prev_ov = 1'b0;
   logic m_act   = 1'b0;
   int   m_left  = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Cycle model of the handshake: 4 busy edges for a mix, none for a bypass.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         m_act  <= 1'b0;
         m_left <= 0;
      end else if (!m_act) begin
         if (bus.in_valid) begin
            m_act  <= 1'b1;
            m_left <= bus.in_last ? 0 : 4;
         end
      end else if (m_left != 0) begin
         m_left <= m_left - 1;
      end else if (bus.out_ready) begin
         m_act <= 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         check("in_ready", bus.in_ready, !m_act);
         check("out_valid", bus.out_valid, m_act && (m_left == 0));
         if (bus.out_valid) begin
            if (q.size() == 0) begin
               check("unexpected_out", bus.out_valid, 1'b0);
            end else begin
               if (!prev_ov) check("latency", cyc - q[0].acc_cyc + 1, q[0].lat);
               check("out_state", bus.out_state, q[0].state);
               if (bus.out_ready) void'(q.pop_front());
            end
         end
      end
      prev_ov = bus.out_valid;
   end

   // Present a state and hold in_valid until accepted; returns on the negedge after the accept edge.
   task automatic send(input t_opaque_AESState s, input logic last, input t_opaque_AESState exp_s);
      logic got;
      exp_t e;
      got          = 1'b0;
      bus.in_state = s;
      bus.in_last  = last;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         if (bus.in_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         check("accept_timeout", bus.in_ready, 1'b1);
      end else begin
         e.state   = exp_s;
         e.acc_cyc = cyc + 1;
         e.lat     = last ? 1 : 5;
         q.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
      check("drain", q.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.in_state  = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", bus.in_ready, 1'b1);
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_out_state", bus.out_state, '0);
      chk_en = 1'b1;

      // FIPS-197 columns
      send(st_a, 1'b0, exp_a);
      bus.in_valid = 1'b0;
      drain();

      // xtime reduction edge bytes
      send(st_e, 1'b0, exp_e);
      bus.in_valid = 1'b0;
      drain();

      // final-round bypass
      send(st_p, 1'b1, st_p);
      bus.in_valid = 1'b0;
      drain();

      // backpressure, with junk offered while the block is occupied
      bus.out_ready = 1'b0;
      send(st_a, 1'b0, exp_a);
      bus.in_state = junk;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
      check("bp_reach_done", bus.out_valid, 1'b1);
      repeat (10) begin
         @(negedge clk);
         check("bp_valid", bus.out_valid, 1'b1);
         check("bp_in_ready", bus.in_ready, 1'b0);
         check("bp_hold", bus.out_state, exp_a);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("bp_release_ready", bus.in_ready, 1'b1);
      check("bp_release_valid", bus.out_valid, 1'b0);
      check("bp_drained", q.size(), 0);

      // reset while column 2 is being processed
      send(st_b, 1'b0, exp_b);
      bus.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      check("abort_in_ready", bus.in_ready, 1'b1);
      check("abort_out_valid", bus.out_valid, 1'b0);
      check("abort_out_state", bus.out_state, '0);
      send(st_e, 1'b0, exp_e);
      bus.in_valid = 1'b0;
      drain();

      // back-to-back with in_valid held high, including a bypass in the middle
      send(st_a, 1'b0, exp_a);
      send(st_p, 1'b1, st_p);
      send(st_b, 1'b0, exp_b);
      bus.in_valid = 1'b0;
      drain();

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 The block SHALL have no parameters; the state type SHALL be t_opaque_AESState, indexed state[c][r] (c = column 0..3, r = row 0..3, one byte each).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_state and in_last are valid this cycle.
REQ-005 in_ready  output  1  block can accept a state this cycle.
REQ-006 in_state  input  t_opaque_AESState (128)  round state produced by shiftRows.
REQ-007 in_last  input  1  final AES round; MixColumns is bypassed.
REQ-008 out_valid  output  1  out_state holds a completed result.
REQ-009 out_ready  input  1  downstream (AddRoundKey) accepts out_state this cycle.
REQ-010 out_state  output  t_opaque_AESState (128)  registered result.

Function
REQ-011 The block SHALL be a three-state FSM: IDLE, BUSY, DONE; col_cnt SHALL be a 2-bit column counter.
REQ-012 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; both outputs SHALL be registered-state decodes.
REQ-013 The accept condition SHALL be in_valid & in_ready; on accept, in_state SHALL be captured into the working register and col_cnt SHALL be set to 0.
REQ-014 IDLE, accept with in_last=0 SHALL transition to BUSY.
REQ-015 IDLE, accept with in_last=1 SHALL load out_state = in_state unchanged and transition to DONE (latency 1 edge).
REQ-016 In each BUSY cycle, column col_cnt SHALL be transformed and written to out_state[col_cnt], and col_cnt SHALL increment.
REQ-017 BUSY with col_cnt=3 SHALL write column 3, wrap col_cnt to 0 and transition to DONE.
REQ-018 The non-bypass latency SHALL be 5 edges from the accept edge to out_valid=1: one load edge plus four column edges (column k written at edge k+2 counting the accept edge as 1).
REQ-019 Column math SHALL use, with a_r = state[c][r], all results 8-bit, and + = XOR:
 - b0 = 2a0+3a1+a2+a3
 - b1 = a0+2a1+3a2+a3
 - b2 = a0+a1+2a2+3a3
 - b3 = 3a0+a1+a2+2a3
REQ-020 GF(2^8) arithmetic SHALL be xtime(x) = (x<<1 truncated to 8 bits) XOR (x[7] ? 0x1B : 0x00) and 3x = xtime(x) XOR x; exactly one column datapath SHALL be instantiated.
REQ-021 In DONE with out_ready=1, the block SHALL transition to IDLE; with out_ready=0 it SHALL stay in DONE and hold out_state bit-stable.
REQ-022 in_valid SHALL be ignored outside IDLE; in_state and in_last changes outside the accept cycle SHALL have no effect.
REQ-023 The block SHALL NOT accept and emit in the same cycle; minimum spacing SHALL be 6 cycles per non-bypass block and 2 cycles per bypass block with out_ready held 1.
REQ-024 out_state columns not yet written in BUSY SHALL be don't-care, since they are not observable while out_valid=0.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL set the FSM to IDLE, col_cnt to 0, and out_state and the working register to all-zero.
REQ-026 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 from the first cycle after the reset edge.
REQ-027 rst asserted in BUSY or DONE SHALL abort the operation and discard the in-flight state, with no out_valid pulse emitted.
REQ-028 rst SHALL take priority over a simultaneous accept or out handshake.

Verification
REQ-029 FIPS-197 column vectors, in_last=0, one per column of one state:
 - db 13 53 45 -> 8e 4d a1 bc
 - f2 0a 22 5c -> 9f dc 58 9d
 - 01 01 01 01 -> 01 01 01 01
 - 2d 26 31 4c -> 4d 7e bd f8
 The bench SHALL check out_valid rising exactly 5 edges after the accept edge.
REQ-030 Bypass: in_state = 00112233..ccddeeff, in_last=1 -> out_state identical, with out_valid 1 edge after accept.
REQ-031 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state stable, in_ready stays 0; raising out_ready -> IDLE on the next edge.
REQ-032 Reset mid-operation: assert rst when col_cnt=2 -> next cycle IDLE, out_valid=0, out_state=0; a new block then completes with correct values.
REQ-033 Back-to-back: 3 states with continuous in_valid and out_ready=1 -> 3 correct results in order, with in_ready=0 throughout each BUSY/DONE period.
REQ-034 Edge bytes: column d4 d4 d4 d5 -> d5 d5 d7 d6, and column c6 c6 c6 c6 -> c6 c6 c6 c6, exercising xtime with a 0x1B reduction.
